// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//
// Pipeline stage register placed between two stages of the RISC-V core.
// Carries a control field and a payload behind a valid/ready handshake.
// With SKID=1 a second (skid) entry is added so that ready_o comes straight
// from a flop and no combinational path runs from ready_i to ready_o.
// With SKID=0 the stage is a single register and ready_o is combinational.
// A synchronous flush turns the stage into a bubble, and a saturating stall
// counter reports how many cycles a held beat waited on downstream.
//
// Handshake: a beat moves on a rising edge when its valid and ready are both
// high in that cycle. Upstream: accept = valid_i & ready_o. Downstream:
// emit = valid_o & ready_i. A producer holding valid may not retract it
// until the beat is taken, except that flush discards whatever is offered.
//
// Parameters
//   CTRL_W  control field width (masked to zero while the stage is empty)
//   DATA_W  payload width
//   SKID    1: skid entry and registered ready_o, 0: single register
//   CNT_W   stall counter width
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active low
//   valid_i      upstream offers a beat
//   ready_o      stage can take a beat this cycle
//   ctrl_i       upstream control field
//   data_i       upstream payload
//   valid_o      stage holds a beat for downstream
//   ready_i      downstream takes the beat
//   ctrl_o       control field, zero when valid_o is low
//   data_o       payload, keeps its last value when valid_o is low
//   flush_i      synchronous kill of every held beat
//   clr_cnt_i    synchronous clear of the stall counter
//   occ_o        number of held beats (0..2)
//   stall_cnt_o  saturating count of cycles with valid_o & ~ready_i
module pipe_stage_reg #(
  parameter int CTRL_W = 2,
  parameter int DATA_W = 69,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              flush_i,
  input  logic              clr_cnt_i,
  output logic [1:0]        occ_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  // Main entry: drives the outputs directly.
  logic              m_valid;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] m_data;

  // Skid entry: only real when SKID=1, tied off otherwise.
  logic              s_valid;
  logic [CTRL_W-1:0] s_ctrl;
  logic [DATA_W-1:0] s_data;

  logic accept;
  logic emit;

  assign emit   = m_valid & ready_i;
  assign accept = valid_i & ready_o;

  generate
    if (SKID != 0) begin : g_skid
      // ready_o is a pure flop output: the stage can always absorb one more
      // beat while the skid entry is free.
      assign ready_o = ~s_valid;

      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          m_valid <= 1'b0;
          m_ctrl  <= '0;
          m_data  <= '0;
          s_valid <= 1'b0;
          s_ctrl  <= '0;
          s_data  <= '0;
        end else if (flush_i) begin
          // Flush wins over everything; a beat offered now is dropped.
          m_valid <= 1'b0;
          m_ctrl  <= '0;
          s_valid <= 1'b0;
        end else if (!m_valid || emit) begin
          if (s_valid) begin
            // Oldest beat is in S: it moves up first to keep order.
            m_valid <= 1'b1;
            m_ctrl  <= s_ctrl;
            m_data  <= s_data;
            if (accept) begin
              s_ctrl <= ctrl_i;
              s_data <= data_i;
            end else begin
              s_valid <= 1'b0;
            end
          end else if (accept) begin
            m_valid <= 1'b1;
            m_ctrl  <= ctrl_i;
            m_data  <= data_i;
          end else begin
            m_valid <= 1'b0;
          end
        end else if (accept) begin
          // M is stuck downstream; the in-flight beat parks in S.
          s_valid <= 1'b1;
          s_ctrl  <= ctrl_i;
          s_data  <= data_i;
        end
      end
    end else begin : g_noskid
      // A full stage can still accept when its beat leaves this same cycle.
      assign ready_o = ~m_valid | ready_i;
      assign s_valid = 1'b0;
      assign s_ctrl  = '0;
      assign s_data  = '0;

      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          m_valid <= 1'b0;
          m_ctrl  <= '0;
          m_data  <= '0;
        end else if (flush_i) begin
          m_valid <= 1'b0;
          m_ctrl  <= '0;
        end else if (accept) begin
          m_valid <= 1'b1;
          m_ctrl  <= ctrl_i;
          m_data  <= data_i;
        end else if (emit) begin
          m_valid <= 1'b0;
        end
      end
    end
  endgenerate

  // Outputs. Only ctrl is masked: a bubble must never look like a live
  // control word, while the payload is don't-care and left unmasked.
  assign valid_o = m_valid;
  assign ctrl_o  = m_ctrl & {CTRL_W{m_valid}};
  assign data_o  = m_data;
  assign occ_o   = {1'b0, m_valid} + {1'b0, s_valid};

  // Stall counter: clear has priority, saturates instead of wrapping,
  // and is deliberately left alone by flush.
  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt <= '0;
    end else if (clr_cnt_i) begin
      stall_cnt <= '0;
    end else if (m_valid && !ready_i && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int CTRL_W = 2;
  localparam int DATA_W = 69;
  localparam int CNT_W  = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared;
  int mismatched;

  // ---------------- DUT with skid (CNT_W=4) ----------------
  logic              valid_i;
  logic              ready_o;
  logic [CTRL_W-1:0] ctrl_i;
  logic [DATA_W-1:0] data_i;
  logic              valid_o;
  logic              ready_i;
  logic [CTRL_W-1:0] ctrl_o;
  logic [DATA_W-1:0] data_o;
  logic              flush_i;
  logic              clr_cnt_i;
  logic [1:0]        occ_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  pipe_stage_reg #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(1), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_i(rst_n),
    .valid_i(valid_i), .ready_o(ready_o), .ctrl_i(ctrl_i), .data_i(data_i),
    .valid_o(valid_o), .ready_i(ready_i), .ctrl_o(ctrl_o), .data_o(data_o),
    .flush_i(flush_i), .clr_cnt_i(clr_cnt_i),
    .occ_o(occ_o), .stall_cnt_o(stall_cnt_o)
  );

  // ---------------- DUT without skid ----------------
  logic              v0_i;
  logic              r0_o;
  logic [CTRL_W-1:0] c0_i;
  logic [DATA_W-1:0] d0_i;
  logic              v0_o;
  logic              r0_i;
  logic [CTRL_W-1:0] c0_o;
  logic [DATA_W-1:0] d0_o;
  logic              f0_i;
  logic              clr0_i;
  logic [1:0]        occ0_o;
  logic [15:0]       cnt0_o;

  pipe_stage_reg #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(0), .CNT_W(16)
  ) dut0 (
    .clk_i(clk), .rst_i(rst_n),
    .valid_i(v0_i), .ready_o(r0_o), .ctrl_i(c0_i), .data_i(d0_i),
    .valid_o(v0_o), .ready_i(r0_i), .ctrl_o(c0_o), .data_o(d0_o),
    .flush_i(f0_i), .clr_cnt_i(clr0_i),
    .occ_o(occ0_o), .stall_cnt_o(cnt0_o)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c,
                       input logic [DATA_W-1:0] d, input logic r);
    valid_i = v;
    ctrl_i  = c;
    data_i  = d;
    ready_i = r;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    compared++;
    if (valid_o !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %0b expected 0", valid_o); end
    compared++;
    if (ctrl_o !== 2'b00) begin mismatched++; $display("FAIL reset_ctrl: got %0h expected 0", ctrl_o); end
    compared++;
    if (data_o !== '0) begin mismatched++; $display("FAIL reset_data: got %0h expected 0", data_o); end
    compared++;
    if (occ_o !== 2'd0) begin mismatched++; $display("FAIL reset_occ: got %0d expected 0", occ_o); end
    compared++;
    if (stall_cnt_o !== 4'd0) begin mismatched++; $display("FAIL reset_cnt: got %0d expected 0", stall_cnt_o); end
    compared++;
    if (ready_o !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %0b expected 1", ready_o); end
    compared++;
    if (r0_o !== 1'b1) begin mismatched++; $display("FAIL reset_ready0: got %0b expected 1", r0_o); end
    compared++;
    if (v0_o !== 1'b0) begin mismatched++; $display("FAIL reset_valid0: got %0b expected 0", v0_o); end
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i > 1) begin
        compared++;
        if (data_o !== DATA_W'(i - 1)) begin mismatched++; $display("FAIL stream_data[%0d]: got %0h expected %0h", i - 1, data_o, i - 1); end
        compared++;
        if (occ_o !== 2'd1) begin mismatched++; $display("FAIL stream_occ[%0d]: got %0d expected 1", i - 1, occ_o); end
        compared++;
        if (ctrl_o !== 2'b01) begin mismatched++; $display("FAIL stream_ctrl[%0d]: got %0h expected 1", i - 1, ctrl_o); end
      end
      drive(1'b1, 2'b01, DATA_W'(i), 1'b1);
    end
    tick();
    compared++;
    if (data_o !== DATA_W'(8)) begin mismatched++; $display("FAIL stream_data[8]: got %0h expected 8", data_o); end
    drive(1'b0, 2'b00, '0, 1'b1);
    tick();
    compared++;
    if (valid_o !== 1'b0) begin mismatched++; $display("FAIL stream_drain_valid: got %0b expected 0", valid_o); end
    compared++;
    if (ctrl_o !== 2'b00) begin mismatched++; $display("FAIL stream_empty_ctrl: got %0h expected 0", ctrl_o); end
    compared++;
    if (stall_cnt_o !== 4'd0) begin mismatched++; $display("FAIL stream_cnt: got %0d expected 0", stall_cnt_o); end
  endtask

  task automatic test_skid();
    drive(1'b1, 2'b01, DATA_W'(10), 1'b1);      // A
    tick();
    compared++;
    if (data_o !== DATA_W'(10)) begin mismatched++; $display("FAIL skid_a: got %0h expected a", data_o); end
    drive(1'b1, 2'b01, DATA_W'(11), 1'b0);      // B, downstream stalls
    tick();
    compared++;
    if (occ_o !== 2'd2) begin mismatched++; $display("FAIL skid_occ2: got %0d expected 2", occ_o); end
    compared++;
    if (ready_o !== 1'b0) begin mismatched++; $display("FAIL skid_ready_low: got %0b expected 0", ready_o); end
    compared++;
    if (data_o !== DATA_W'(10)) begin mismatched++; $display("FAIL skid_a_held: got %0h expected a", data_o); end
    drive(1'b1, 2'b01, DATA_W'(12), 1'b1);      // C offered, refused this cycle
    tick();
    compared++;
    if (data_o !== DATA_W'(11)) begin mismatched++; $display("FAIL skid_b: got %0h expected b", data_o); end
    compared++;
    if (ready_o !== 1'b1) begin mismatched++; $display("FAIL skid_ready_back: got %0b expected 1", ready_o); end
    compared++;
    if (occ_o !== 2'd1) begin mismatched++; $display("FAIL skid_occ1: got %0d expected 1", occ_o); end
    tick();                                      // C accepted while B leaves
    compared++;
    if (data_o !== DATA_W'(12)) begin mismatched++; $display("FAIL skid_c: got %0h expected c", data_o); end
    drive(1'b0, 2'b00, '0, 1'b1);
    tick();
    compared++;
    if (valid_o !== 1'b0) begin mismatched++; $display("FAIL skid_no_dup: got %0b expected 0", valid_o); end
    compared++;
    if (stall_cnt_o !== 4'd1) begin mismatched++; $display("FAIL skid_cnt: got %0d expected 1", stall_cnt_o); end
  endtask

  task automatic test_flush();
    drive(1'b1, 2'b11, DATA_W'(20), 1'b0);
    tick();
    drive(1'b1, 2'b11, DATA_W'(21), 1'b0);
    tick();
    compared++;
    if (occ_o !== 2'd2) begin mismatched++; $display("FAIL flush_pre_occ: got %0d expected 2", occ_o); end
    compared++;
    if (ctrl_o !== 2'b11) begin mismatched++; $display("FAIL flush_pre_ctrl: got %0h expected 3", ctrl_o); end
    drive(1'b1, 2'b11, DATA_W'(99), 1'b0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    compared++;
    if (valid_o !== 1'b0) begin mismatched++; $display("FAIL flush_valid: got %0b expected 0", valid_o); end
    compared++;
    if (ctrl_o !== 2'b00) begin mismatched++; $display("FAIL flush_ctrl: got %0h expected 0", ctrl_o); end
    compared++;
    if (occ_o !== 2'd0) begin mismatched++; $display("FAIL flush_occ: got %0d expected 0", occ_o); end
    compared++;
    if (ready_o !== 1'b1) begin mismatched++; $display("FAIL flush_ready: got %0b expected 1", ready_o); end
    // Two stall cycles before and during the flush; flush keeps the count.
    compared++;
    if (stall_cnt_o !== 4'd3) begin mismatched++; $display("FAIL flush_cnt_kept: got %0d expected 3", stall_cnt_o); end
    drive(1'b0, 2'b00, '0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      compared++;
      if (valid_o !== 1'b0) begin mismatched++; $display("FAIL flush_dropped[%0d]: got %0b expected 0", k, valid_o); end
    end
  endtask

  task automatic test_stall_sat();
    drive(1'b1, 2'b10, DATA_W'(30), 1'b0);
    clr_cnt_i = 1'b1;
    tick();
    clr_cnt_i = 1'b0;
    compared++;
    if (stall_cnt_o !== 4'd0) begin mismatched++; $display("FAIL sat_clear0: got %0d expected 0", stall_cnt_o); end
    drive(1'b1, 2'b10, DATA_W'(31), 1'b0);
    tick();
    drive(1'b0, 2'b00, '0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      compared++;
      if (stall_cnt_o !== CNT_W'((k > 15) ? 15 : k)) begin mismatched++; $display("FAIL sat_cnt[%0d]: got %0d expected %0d", k, stall_cnt_o, (k > 15) ? 15 : k); end
      if (k == 20) begin
        compared++;
        if (occ_o !== 2'd2 || ready_o !== 1'b0 || data_o !== DATA_W'(30)) begin
          mismatched++;
          $display("FAIL full_hold: got occ %0d ready %0b data %0h expected 2 0 1e", occ_o, ready_o, data_o);
        end
      end
      tick();
    end
    compared++;
    if (stall_cnt_o !== 4'd15) begin mismatched++; $display("FAIL sat_stay: got %0d expected 15", stall_cnt_o); end
    clr_cnt_i = 1'b1;                             // clear during a stall cycle
    tick();
    clr_cnt_i = 1'b0;
    compared++;
    if (stall_cnt_o !== 4'd0) begin mismatched++; $display("FAIL sat_clr: got %0d expected 0", stall_cnt_o); end
    ready_i = 1'b1;
    tick();
    compared++;
    if (data_o !== DATA_W'(31) || valid_o !== 1'b1) begin mismatched++; $display("FAIL sat_drain_b: got %0h expected 1f", data_o); end
    tick();
    compared++;
    if (valid_o !== 1'b0) begin mismatched++; $display("FAIL sat_drain_empty: got %0b expected 0", valid_o); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 2'b11, DATA_W'(40), 1'b0);
    tick();
    drive(1'b1, 2'b11, DATA_W'(41), 1'b0);
    tick();
    drive(1'b0, 2'b00, '0, 1'b0);
    compared++;
    if (occ_o !== 2'd2) begin mismatched++; $display("FAIL rmid_pre_occ: got %0d expected 2", occ_o); end
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if (valid_o !== 1'b0 || ctrl_o !== 2'b00 || data_o !== '0) begin
      mismatched++;
      $display("FAIL rmid_outputs: got v %0b c %0h d %0h expected 0 0 0", valid_o, ctrl_o, data_o);
    end
    compared++;
    if (occ_o !== 2'd0) begin mismatched++; $display("FAIL rmid_occ: got %0d expected 0", occ_o); end
    compared++;
    if (stall_cnt_o !== 4'd0) begin mismatched++; $display("FAIL rmid_cnt: got %0d expected 0", stall_cnt_o); end
    compared++;
    if (ready_o !== 1'b1) begin mismatched++; $display("FAIL rmid_ready: got %0b expected 1", ready_o); end
    tick();
    rst_n = 1'b1;
    ready_i = 1'b1;
  endtask

  task automatic test_noskid();
    v0_i = 1'b1; c0_i = 2'b10; d0_i = DATA_W'(50); r0_i = 1'b0;
    #1;
    compared++;
    if (r0_o !== 1'b1) begin mismatched++; $display("FAIL ns_ready_empty: got %0b expected 1", r0_o); end
    tick();
    compared++;
    if (r0_o !== 1'b0) begin mismatched++; $display("FAIL ns_ready_full: got %0b expected 0", r0_o); end
    compared++;
    if (v0_o !== 1'b1 || d0_o !== DATA_W'(50) || occ0_o !== 2'd1) begin
      mismatched++;
      $display("FAIL ns_load: got v %0b d %0h occ %0d expected 1 32 1", v0_o, d0_o, occ0_o);
    end
    d0_i = DATA_W'(51); c0_i = 2'b01; r0_i = 1'b1;
    #1;
    compared++;
    if (r0_o !== 1'b1) begin mismatched++; $display("FAIL ns_ready_comb: got %0b expected 1", r0_o); end
    tick();
    compared++;
    if (d0_o !== DATA_W'(51) || c0_o !== 2'b01 || occ0_o !== 2'd1) begin
      mismatched++;
      $display("FAIL ns_replace: got d %0h c %0h occ %0d expected 33 1 1", d0_o, c0_o, occ0_o);
    end
    v0_i = 1'b0;
    tick();
    compared++;
    if (v0_o !== 1'b0 || c0_o !== 2'b00) begin mismatched++; $display("FAIL ns_empty: got v %0b c %0h expected 0 0", v0_o, c0_o); end
    compared++;
    if (cnt0_o !== 16'd0) begin mismatched++; $display("FAIL ns_cnt: got %0d expected 0", cnt0_o); end
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    drive(1'b0, 2'b00, '0, 1'b1);
    flush_i    = 1'b0;
    clr_cnt_i  = 1'b0;
    v0_i = 1'b0; c0_i = '0; d0_i = '0; r0_i = 1'b1; f0_i = 1'b0; clr0_i = 1'b0;
    #12;
    test_reset();
    tick();
    rst_n = 1'b1;
    test_streaming();
    test_skid();
    test_flush();
    test_stall_sat();
    test_reset_mid();
    test_noskid();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
